axil_rd_arbiter: RTL and testbench
==================================

# axil_rd_arbiter

Shares a single AXI4-Lite read channel (AR and R) among NUM_REQ local requesters. Each requester presents an address and gets one data/response pulse back. Selection is round-robin, and only one read is outstanding at a time. The block sits between the register-access clients and the AXI4-Lite interconnect. It replaces per-client read masters with one sequenced port.

## Interface
Parameters:
- NUM_REQ, 4: number of requesters, 2..8
- ADDR_W, 32: address width
- DATA_W, 32: data width
- TIMEOUT_CYC, 255: R-phase watchdog limit in cycles; used only with the macro in Configuration

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- req  in  NUM_REQ  per-requester read request, level
- req_addr  in  NUM_REQ*ADDR_W  packed addresses; requester i occupies bits [i*ADDR_W +: ADDR_W]
- rsp_valid  out  NUM_REQ  one-hot, one-cycle completion pulse
- rsp_data  out  DATA_W  read data, valid while rsp_valid is nonzero
- rsp_resp  out  2  AXI response code, valid while rsp_valid is nonzero
- arvalid  out  1  AXI AR valid
- arready  in  1  AXI AR ready
- araddr  out  ADDR_W  AXI AR address
- arprot  out  3  tied to 3'b000
- rvalid  in  1  AXI R valid
- rready  out  1  AXI R ready
- rdata  in  DATA_W  AXI R data
- rresp  in  2  AXI R response

## Operation
All outputs are registered except arprot.

Reset values: arvalid=0, araddr=0, rready=0, rsp_valid=0, rsp_data=0, rsp_resp=0, state=IDLE, round-robin pointer=0.

State machine:
- IDLE: if any req bit is set, grant the first set bit searching from ptr+1 upward with wrap-around. Latch the grant index and that requester's address. arvalid=1 and araddr are loaded on the same edge. Next state is ADDR. With no request, stay in IDLE.
- ADDR: hold arvalid and araddr stable. When arready=1, clear arvalid, set rready=1 and go to DATA.
- DATA: hold rready. When rvalid=1, clear rready, capture rdata into rsp_data and rresp into rsp_resp, set rsp_valid[grant]=1, set ptr=grant and go to RESP.
- RESP: rsp_valid is high for exactly this cycle. Clear it and return to IDLE.

Requester rules:
- A requester holds req and its address until it sees its rsp_valid bit.
- It deasserts req on the edge ending the RESP cycle.
- Dropping req after grant has no effect: the transaction completes and the pulse is still issued.
- rresp is passed through unmodified, including SLVERR and DECERR.

Boundary conditions:
- Single requester: back-to-back reads are served every 4 cycles minimum.
- All requesters active: each is served once per NUM_REQ transactions.
- Reset asserted mid-transaction: all outputs clear immediately and asynchronously. The in-flight AXI transaction is abandoned, which is accepted only because reset is system-wide.

## Timing
- req is sampled at edge T in IDLE. arvalid is high from T+1.
- If arready=1 in the first ADDR cycle, rready is high from T+2.
- If rvalid=1 in the first DATA cycle, rsp_valid is high at T+3 and IDLE resumes at T+4.
- Minimum request-to-response latency is 3 cycles. Each arready or rvalid wait state adds 1 cycle.

## Configuration
Macro: AXIL_RD_ARB_TIMEOUT_EN.

With the macro defined:
- A counter runs in DATA and clears on entry.
- If TIMEOUT_CYC cycles elapse without rvalid, go to RESP with rsp_resp=2'b10 and rsp_data=0. A sticky stale flag is set.
- While stale is set, rready=1 in IDLE and ADDR. The next R beat is discarded and clears stale.
- IDLE does not grant while stale is set.

Without the macro: there is no counter and no stale flag, and DATA waits indefinitely.

## Structure
- Package axil_rd_arb_pkg holds:
  - the state enum IDLE/ADDR/DATA/RESP
  - response constants RESP_OKAY=2'b00 and RESP_SLVERR=2'b10
  - the index-width function clog2(NUM_REQ)
- Sub-module axil_rr_pick is combinational. Inputs are req and ptr; outputs are grant index and any_req. It is instantiated once.

## Test plan
- Single read: req[0] with 0x1000; arready and rvalid immediate, rdata=0xDEADBEEF. Expect rsp_valid=4'b0001 at T+3 with rsp_data=0xDEADBEEF and rsp_resp=0.
- Round-robin: req=4'b1111 held for 4 transactions starting from ptr=0. Expect grant order 1,2,3,0 and araddr matching each requester.
- Wait states: arready delayed 3 cycles and rvalid delayed 5 cycles. Expect arvalid and araddr stable throughout, and rsp_valid at T+11.
- Error pass-through: rresp=2'b11. Expect rsp_resp=2'b11 on the pulse.
- Reset in DATA: pulse rst_n low. Expect arvalid, rready and rsp_valid at 0 with no clock edge needed, and the next grant goes to requester 1.
- Timeout (macro defined, TIMEOUT_CYC=8): rvalid is withheld. Expect rsp_resp=2'b10 after 8 DATA cycles. A late rvalid is then sunk with no rsp_valid, and the next request proceeds normally.

Source files
------------

// File: rtl/axil_rd_arb_pkg.sv
// ============================================================================
// Module   : axil_rd_arb_pkg
// Brief    : Shared types, response codes and sizing helper for the
//            AXI4-Lite read arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package axil_rd_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    RESP = 2'd3
  } arb_state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Index width for n items; never below 1 so a 2-entry index still has a bit.
  function automatic int clog2(input int n);
    int w;
    w = 1;
    for (int i = 1; i < 32; i++) begin
      if ((1 << w) < n) w = w + 1;
    end
    return w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/axil_rr_pick.sv
// ============================================================================
// Module   : axil_rr_pick
// Brief    : Combinational round-robin picker; first set request after ptr.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module axil_rr_pick
  import axil_rd_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [IDX_W-1:0]   grant,
  output logic               any_req
);

  logic [2*NUM_REQ-1:0] w_dbl;
  logic [NUM_REQ-1:0]   w_rot;

  // Rotating a doubled copy puts requester ptr+1 at bit 0, so the lowest
  // set bit of w_rot is the next requester in round-robin order.
  always_comb begin
    w_dbl   = {req, req};
    w_rot   = NUM_REQ'(w_dbl >> (int'(ptr) + 1));
    grant   = ptr;
    any_req = |req;
    for (int o = NUM_REQ - 1; o >= 0; o--) begin
      if (w_rot[o]) grant = IDX_W'((int'(ptr) + 1 + o) % NUM_REQ);
    end
  end

endmodule

`default_nettype wire

// File: rtl/axil_rd_arbiter.sv
// ============================================================================
// Module   : axil_rd_arbiter
// Brief    : Round-robin sharing of one AXI4-Lite read channel among NUM_REQ
//            requesters, one read outstanding. Optional R-phase watchdog
//            enabled by macro AXIL_RD_ARB_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module axil_rd_arbiter
  import axil_rd_arb_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_data,
  output logic [1:0]                rsp_resp,
  output logic                      arvalid,
  input  logic                      arready,
  output logic [ADDR_W-1:0]         araddr,
  output logic [2:0]                arprot,
  input  logic                      rvalid,
  output logic                      rready,
  input  logic [DATA_W-1:0]         rdata,
  input  logic [1:0]                rresp
);

  localparam int IDX_W = clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
    $error("axil_rd_arbiter: NUM_REQ must be in 2..8");
  end
  if (TIMEOUT_CYC < 1) begin : g_bad_timeout
    $error("axil_rd_arbiter: TIMEOUT_CYC must be at least 1");
  end

  arb_state_e          state_q;
  logic [IDX_W-1:0]    ptr_q;
  logic [IDX_W-1:0]    grant_q;
  logic                arvalid_q;
  logic [ADDR_W-1:0]   araddr_q;
  logic                rready_q;
  logic [NUM_REQ-1:0]  rsp_valid_q;
  logic [DATA_W-1:0]   rsp_data_q;
  logic [1:0]          rsp_resp_q;

  logic [IDX_W-1:0]    w_grant;
  logic                w_any_req;
  logic                w_stale;

`ifdef AXIL_RD_ARB_TIMEOUT_EN
  localparam int TMO_W = clog2(TIMEOUT_CYC + 1);
  logic [TMO_W-1:0] tmo_cnt_q;
  logic             stale_q;
  assign w_stale = stale_q;
`else
  assign w_stale = 1'b0;
`endif

  axil_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req     (req),
    .ptr     (ptr_q),
    .grant   (w_grant),
    .any_req (w_any_req)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      grant_q     <= '0;
      arvalid_q   <= 1'b0;
      araddr_q    <= '0;
      rready_q    <= 1'b0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      rsp_resp_q  <= RESP_OKAY;
`ifdef AXIL_RD_ARB_TIMEOUT_EN
      tmo_cnt_q   <= '0;
      stale_q     <= 1'b0;
`endif
    end else begin
      rsp_valid_q <= '0;
      case (state_q)
        IDLE: begin
          if (w_any_req && !w_stale) begin
            grant_q   <= w_grant;
            araddr_q  <= req_addr[w_grant*ADDR_W +: ADDR_W];
            arvalid_q <= 1'b1;
            state_q   <= ADDR;
          end
        end
        ADDR: begin
          if (arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= DATA;
`ifdef AXIL_RD_ARB_TIMEOUT_EN
            tmo_cnt_q <= '0;
`endif
          end
        end
        DATA: begin
          if (rvalid) begin
            rready_q    <= 1'b0;
            rsp_data_q  <= rdata;
            rsp_resp_q  <= rresp;
            rsp_valid_q <= NUM_REQ'(1) << grant_q;
            ptr_q       <= grant_q;
            state_q     <= RESP;
          end
`ifdef AXIL_RD_ARB_TIMEOUT_EN
          // rready stays high so the late beat is sunk once it arrives.
          else if (tmo_cnt_q == TMO_W'(TIMEOUT_CYC - 1)) begin
            rsp_data_q  <= '0;
            rsp_resp_q  <= RESP_SLVERR;
            rsp_valid_q <= NUM_REQ'(1) << grant_q;
            ptr_q       <= grant_q;
            stale_q     <= 1'b1;
            state_q     <= RESP;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
          end
`endif
        end
        RESP: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
`ifdef AXIL_RD_ARB_TIMEOUT_EN
      if (stale_q && rvalid) begin
        stale_q  <= 1'b0;
        rready_q <= 1'b0;
      end
`endif
    end
  end

  assign arvalid   = arvalid_q;
  assign araddr    = araddr_q;
  assign arprot    = 3'b000;
  assign rready    = rready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_resp  = rsp_resp_q;

endmodule

`default_nettype wire

// File: tb/tb_axil_rd_arbiter.sv
// ============================================================================
// Module   : tb_axil_rd_arbiter
// Brief    : Self-checking bench for axil_rd_arbiter with a round-robin and
//            latency reference model; timeout steps under AXIL_RD_ARB_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_axil_rd_arbiter;

  localparam int NUM_REQ = 4;
  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int TMO     = 8;

  logic                      clk;
  logic                      rst_n;
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]         rsp_data;
  logic [1:0]                rsp_resp;
  logic                      arvalid;
  logic                      arready;
  logic [ADDR_W-1:0]         araddr;
  logic [2:0]                arprot;
  logic                      rvalid;
  logic                      rready;
  logic [DATA_W-1:0]         rdata;
  logic [1:0]                rresp;

  axil_rd_arbiter #(
    .NUM_REQ     (NUM_REQ),
    .ADDR_W      (ADDR_W),
    .DATA_W      (DATA_W),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .req_addr  (req_addr),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_resp  (rsp_resp),
    .arvalid   (arvalid),
    .arready   (arready),
    .araddr    (araddr),
    .arprot    (arprot),
    .rvalid    (rvalid),
    .rready    (rready),
    .rdata     (rdata),
    .rresp     (rresp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  logic [ADDR_W-1:0]  addr_tab [NUM_REQ];
  logic [NUM_REQ-1:0] pending;
  int                 model_ptr;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference arbitration: first pending requester after the last one served.
  function automatic int model_next(input logic [NUM_REQ-1:0] m, input int p);
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (m[(p + k) % NUM_REQ]) return (p + k) % NUM_REQ;
    end
    return -1;
  endfunction

  task automatic drive_req();
    req = pending;
    for (int i = 0; i < NUM_REQ; i++) req_addr[i*ADDR_W +: ADDR_W] = addr_tab[i];
  endtask

  task automatic add_req(input int i);
    if (!pending[i]) begin
      pending[i]  = 1'b1;
      addr_tab[i] = $urandom & 32'hFFFF_FFFC;
    end
  endtask

  // Called at a negedge with the DUT idle; r_wait < 0 withholds rvalid.
  task automatic txn(input int ar_wait, input int r_wait, input logic [31:0] data,
                     input logic [1:0] resp, input bit drop_early, output int g);
    int          ar_cnt;
    int          r_cnt;
    int          exp_k;
    bit          done;
    logic [31:0] exp_data;
    logic [1:0]  exp_resp;
    g        = model_next(pending, model_ptr);
    exp_k    = (r_wait < 0) ? 2 + ar_wait + TMO : 3 + ar_wait + r_wait;
    exp_data = (r_wait < 0) ? 32'h0 : data;
    exp_resp = (r_wait < 0) ? 2'b10 : resp;
    ar_cnt   = 0;
    r_cnt    = 0;
    done     = 1'b0;
    drive_req();
    for (int k = 1; k <= 64 && !done; k++) begin
      @(negedge clk);
      if (k == 1) begin
        chk("arvalid_after_sample", arvalid, 1);
        if (drop_early) begin
          pending[g] = 1'b0;
          drive_req();
        end
      end
      if (rsp_valid != '0) begin
        done = 1'b1;
        chk("rsp_latency", k, exp_k);
        chk("rsp_valid_onehot", rsp_valid, 64'(1) << g);
        chk("rsp_data", rsp_data, exp_data);
        chk("rsp_resp", rsp_resp, exp_resp);
        chk("arvalid_cycles", ar_cnt, ar_wait + 1);
        chk("rready_cycles", r_cnt, (r_wait < 0) ? TMO : r_wait + 1);
        chk("rready_on_pulse", rready, (r_wait < 0) ? 1 : 0);
        rvalid = 1'b0;
      end else begin
        if (arvalid) begin
          ar_cnt++;
          chk("araddr_hold", araddr, addr_tab[g]);
          arready = (ar_cnt > ar_wait);
        end else begin
          arready = 1'b0;
        end
        if (rready) begin
          r_cnt++;
          rvalid = (r_wait >= 0) && (r_cnt > r_wait);
          rdata  = rvalid ? data : $urandom;
          rresp  = rvalid ? resp : 2'($urandom);
        end else begin
          rvalid = 1'b0;
        end
      end
    end
    chk("rsp_seen_in_budget", done, 1);
    @(negedge clk);
    chk("rsp_pulse_one_cycle", rsp_valid, 0);
    pending[g] = 1'b0;
    model_ptr  = g;
    drive_req();
  endtask

  initial begin
    #200000;
    $display("FAIL global_watchdog: simulation time limit reached, expected completion");
    $fatal(1, "bench watchdog");
  end

  initial begin
    int g;
    rst_n    = 1'b0;
    req      = '0;
    req_addr = '0;
    arready  = 1'b0;
    rvalid   = 1'b0;
    rdata    = '0;
    rresp    = '0;
    pending  = '0;
    model_ptr = 0;
    for (int i = 0; i < NUM_REQ; i++) addr_tab[i] = '0;

    repeat (2) @(negedge clk);
    chk("reset_arvalid", arvalid, 0);
    chk("reset_araddr", araddr, 0);
    chk("reset_rready", rready, 0);
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_rsp_data", rsp_data, 0);
    chk("reset_rsp_resp", rsp_resp, 0);
    chk("arprot_tied", arprot, 0);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("idle_no_req_arvalid", arvalid, 0);
    end

    // Single read from requester 0.
    pending[0]  = 1'b1;
    addr_tab[0] = 32'h0000_1000;
    txn(0, 0, 32'hDEAD_BEEF, 2'b00, 1'b0, g);
    chk("single_grant", g, 0);

    // All four requesting from ptr=0: order 1,2,3,0.
    for (int i = 0; i < NUM_REQ; i++) add_req(i);
    for (int n = 0; n < NUM_REQ; n++) begin
      txn(0, 0, $urandom, 2'b00, 1'b0, g);
      chk("rr_grant_order", g, (n + 1) % NUM_REQ);
    end

    // Wait states: 3 on AR, 5 on R.
    add_req(2);
    txn(3, 5, $urandom, 2'b00, 1'b0, g);

    // Error responses pass through untouched.
    add_req(3);
    txn(0, 0, $urandom, 2'b11, 1'b0, g);
    add_req(1);
    txn(0, 1, $urandom, 2'b10, 1'b0, g);

    // Requester drops req right after grant; pulse still issued.
    add_req(0);
    txn(1, 1, $urandom, 2'b01, 1'b1, g);

    // Randomized traffic.
    repeat (40) begin
      add_req(int'($urandom_range(0, NUM_REQ - 1)));
      if ($urandom_range(0, 1) == 1) add_req(int'($urandom_range(0, NUM_REQ - 1)));
      txn(int'($urandom_range(0, 3)), int'($urandom_range(0, 4)), $urandom,
          2'($urandom), 1'b0, g);
    end

    // Asynchronous reset while in DATA.
    add_req(1);
    add_req(2);
    drive_req();
    arready = 1'b1;
    @(negedge clk);
    chk("pre_reset_arvalid", arvalid, 1);
    @(negedge clk);
    chk("pre_reset_rready", rready, 1);
    arready = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("async_reset_arvalid", arvalid, 0);
    chk("async_reset_rready", rready, 0);
    chk("async_reset_rsp_valid", rsp_valid, 0);
    chk("async_reset_araddr", araddr, 0);
    @(negedge clk);
    rst_n     = 1'b1;
    model_ptr = 0;
    txn(0, 0, $urandom, 2'b00, 1'b0, g);
    chk("post_reset_grant", g, 1);

`ifdef AXIL_RD_ARB_TIMEOUT_EN
    // Withheld rvalid: timeout response, then a late beat is sunk.
    add_req(0);
    txn(0, -1, 32'h0, 2'b00, 1'b0, g);
    chk("stale_rready_idle", rready, 1);
    add_req(3);
    drive_req();
    repeat (3) begin
      @(negedge clk);
      chk("stale_blocks_grant", arvalid, 0);
      chk("stale_rready_hold", rready, 1);
    end
    rvalid = 1'b1;
    rdata  = $urandom;
    rresp  = 2'b00;
    @(negedge clk);
    rvalid = 1'b0;
    chk("late_beat_no_pulse", rsp_valid, 0);
    chk("late_beat_rready_clear", rready, 0);
    chk("late_beat_no_grant_yet", arvalid, 0);
    txn(0, 0, $urandom, 2'b00, 1'b0, g);
    chk("post_timeout_grant", g, 3);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
